timekeeper_sync_sequencer: RTL and testbench
============================================

Name: timekeeper_sync_sequencer

Overview:
Sequences the GPS-to-FPGA time synchronization handshake that feeds the timekeeper. It qualifies the flight-computer (FC) GPS lock, captures the FC-supplied start time, arms PPS capture, and drives the 16-bit FPGA_FC sync register and the 64-bit start-time bus in the required order. After the timekeeper reports ready, it supervises PPS health and falls back to resync on lock loss, PPS loss or FC request.

Parameters:
LOCK_STABLE_CYCLES, 1050, cycles fc_gps_locked_p must be continuously high before the lock is accepted.
PPS_TIMEOUT_CYCLES, 157500000, maximum cycles between PPS edges (1.5 s at 105 MHz) in WAIT_PPS and SYNCED.
READY_TIMEOUT_CYCLES, 1050, maximum cycles from start_time_ready until timekeeper_ready_p.
PPS_SYNC_STAGES, 2, synchronizer depth for pps_gps_p (minimum 2).

Ports:
clk210_p  in  1  system clock, 105 MHz; sole clock.
reset_p  in  1  asynchronous, active-low reset.
fc_gps_locked_p  in  1  level; FC reports GPS lock.
fc_start_time_p  in  64  GPS start time for the next PPS.
fc_start_time_valid_p  in  1  one-cycle strobe qualifying fc_start_time_p.
fc_resync_req_p  in  1  one-cycle strobe; FC forces a resync.
pps_gps_p  in  1  raw asynchronous GPS PPS.
timekeeper_ready_p  in  1  timekeeper ready.
FPGA_FC_sync_reg_p  out  16  [0] lock_ready, [1] pps_look, [2] start_time_ready, [15:3] driven 0.
FC_GPS_start_time_p  out  64  held start time presented to the timekeeper.
sync_done_p  out  1  high while in SYNCED.
pps_missing_p  out  1  sticky fault flag; cleared on re-entry to ARM.
seq_state_p  out  3  current state encoding, for debug.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; holding register 0. Reset asserted mid-operation returns to IDLE immediately; no partial outputs.
- PPS path: PPS_SYNC_STAGES-flop synchronizer followed by a rising-edge detector. pps_edge is a one-cycle pulse 3 cycles after the raw rise with default stages. A level held high produces exactly one edge.
- State encoding: IDLE=0, WAIT_LOCK=1, WAIT_TIME=2, ARM=3, WAIT_PPS=4, WAIT_READY=5, SYNCED=6, FAULT=7.
- IDLE: go to WAIT_LOCK on the next cycle.
- WAIT_LOCK:
  - Stable counter increments while locked and clears when lock is low.
  - At LOCK_STABLE_CYCLES consecutive high cycles, go to WAIT_TIME.
- WAIT_TIME:
  - On fc_start_time_valid_p, latch fc_start_time_p into the holding register and go to ARM.
  - A valid strobe arriving in any earlier state is ignored.
- ARM: one cycle. Clears pps_missing_p and the PPS counter, then goes to WAIT_PPS.
- WAIT_PPS:
  - A new valid strobe overwrites the holding register (latest wins).
  - On pps_edge, go to WAIT_READY.
  - If the PPS counter reaches PPS_TIMEOUT_CYCLES, set pps_missing_p and go to FAULT.
- WAIT_READY:
  - The holding register is frozen.
  - On timekeeper_ready_p, go to SYNCED.
  - If the counter reaches READY_TIMEOUT_CYCLES, go to FAULT.
- SYNCED:
  - The PPS counter restarts on each pps_edge.
  - If it reaches PPS_TIMEOUT_CYCLES, set pps_missing_p and go to FAULT.
- FAULT: one cycle, then WAIT_LOCK.
- Register bits:
  - bit0 = 1 in ARM through SYNCED.
  - bit1 = 1 in ARM and WAIT_PPS.
  - bit2 = 1 in WAIT_READY and SYNCED.
  - All registered; they change the cycle after the state transition.
- FC_GPS_start_time_p continuously reflects the holding register.
- Global overrides, checked in any state from WAIT_TIME onward, priority high to low:
  1. fc_gps_locked_p low: go to WAIT_LOCK.
  2. fc_resync_req_p: go to WAIT_LOCK.
  3. Normal transitions.
- Simultaneous events:
  - Lock loss or resync in the same cycle as pps_edge: the override wins.
  - Valid strobe coincident with pps_edge in WAIT_PPS: the strobe is discarded and the old value is used.
  - PPS timeout coincident with pps_edge: the edge wins.
- Counters saturate at their terminal value. Widths are $clog2 of each parameter + 1; no wrap-around.

Decomposition:
- Package timekeeper_sync_pkg holds the state enum, the sync-register bit index constants (LOCK_READY_BIT=0, PPS_LOOK_BIT=1, START_TIME_READY_BIT=2), and the 105 MHz clock constant.
- One sub-module, pps_edge_sync: synchronizer plus rising-edge detect, parameterized by stage count.
- The FSM and counters stay in the top.

Test Plan:
1. Use LOCK_STABLE_CYCLES=8. Lock high 7 cycles, low 1 cycle, high 8 cycles -> WAIT_TIME entered only after the second run; reg=0x0000 throughout.
2. Nominal sequence: lock, valid with 0x0000_0001_2345_6789, PPS rise, timekeeper_ready 5 cycles later.
   - reg goes 0x0003 -> 0x0005 three cycles after the PPS rise (plus one register cycle).
   - sync_done_p=1; FC_GPS_start_time_p=0x0000_0001_2345_6789.
3. Use PPS_TIMEOUT_CYCLES=100. No PPS in WAIT_PPS -> pps_missing_p=1 at cycle 100; FAULT then WAIT_LOCK; reg=0x0000.
4. Second valid (0xAAAA) in WAIT_PPS, then a valid (0xBBBB) coincident with pps_edge -> output stays 0xAAAA.
5. In SYNCED, drop lock in the same cycle as pps_edge -> WAIT_LOCK; reg=0x0000 next cycle; sync_done_p=0.
6. Assert reset_p low asynchronously mid-WAIT_READY -> all outputs 0 immediately; state IDLE; after release, WAIT_LOCK on the first clock.

Source files
------------

// File: rtl/timekeeper_sync_pkg.sv
// timekeeper_sync_pkg: shared state encoding, sync-register bit map and clock constant
package timekeeper_sync_pkg;
   localparam int unsigned CLK_FREQ_HZ = 105_000_000;
   localparam int LOCK_READY_BIT = 0;
   localparam int PPS_LOOK_BIT = 1;
   localparam int START_TIME_READY_BIT = 2;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_LOCK  = 3'd1,
      WAIT_TIME  = 3'd2,
      ARM        = 3'd3,
      WAIT_PPS   = 3'd4,
      WAIT_READY = 3'd5,
      SYNCED     = 3'd6,
      FAULT      = 3'd7
   } seq_state_t;
endpackage

// File: rtl/timekeeper_sync_sequencer_pps_edge_sync.sv
// pps_edge_sync: multi-flop synchronizer for raw PPS followed by a one-cycle rising-edge pulse
module pps_edge_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pps_async,
   output logic pps_edge
);
   logic [STAGES-1:0] sync_q;
   logic last_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pps_async};
         last_q <= sync_q[STAGES-1];
      end
   end
   assign pps_edge = sync_q[STAGES-1] & ~last_q;
endmodule

// File: rtl/timekeeper_sync_sequencer.sv
// timekeeper_sync_sequencer: GPS lock / start-time / PPS handshake sequencer feeding the timekeeper,
// with PPS health supervision and fallback to resync.
module timekeeper_sync_sequencer
   import timekeeper_sync_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES   = 1050,
   parameter int unsigned PPS_TIMEOUT_CYCLES   = CLK_FREQ_HZ + CLK_FREQ_HZ / 2,
   parameter int unsigned READY_TIMEOUT_CYCLES = 1050,
   parameter int unsigned PPS_SYNC_STAGES      = 2
) (
   input  logic        clk210_p,
   input  logic        reset_p,
   input  logic        fc_gps_locked_p,
   input  logic [63:0] fc_start_time_p,
   input  logic        fc_start_time_valid_p,
   input  logic        fc_resync_req_p,
   input  logic        pps_gps_p,
   input  logic        timekeeper_ready_p,
   output logic [15:0] FPGA_FC_sync_reg_p,
   output logic [63:0] FC_GPS_start_time_p,
   output logic        sync_done_p,
   output logic        pps_missing_p,
   output logic [2:0]  seq_state_p
);
   localparam int LW = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int PW = $clog2(PPS_TIMEOUT_CYCLES) + 1;
   localparam int RW = $clog2(READY_TIMEOUT_CYCLES) + 1;

   seq_state_t state_q, state_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
   logic [PW-1:0] pps_cnt_q, pps_cnt_d, pps_inc;
   logic [RW-1:0] rdy_cnt_q, rdy_cnt_d, rdy_inc;
   logic [63:0] hold_q, hold_d;
   logic [15:0] sync_reg_d;
   logic missing_d, pps_edge, lock_done, pps_to, rdy_to, ovr;

   pps_edge_sync #(.STAGES(PPS_SYNC_STAGES)) u_pps (
      .clk(clk210_p),
      .rst_n(reset_p),
      .pps_async(pps_gps_p),
      .pps_edge(pps_edge)
   );

   // counters saturate at their terminal value instead of wrapping
   assign lock_inc = (lock_cnt_q == LW'(LOCK_STABLE_CYCLES)) ? lock_cnt_q : lock_cnt_q + 1'b1;
   assign pps_inc = (pps_cnt_q == PW'(PPS_TIMEOUT_CYCLES)) ? pps_cnt_q : pps_cnt_q + 1'b1;
   assign rdy_inc = (rdy_cnt_q == RW'(READY_TIMEOUT_CYCLES)) ? rdy_cnt_q : rdy_cnt_q + 1'b1;
   assign lock_done = fc_gps_locked_p && lock_cnt_q >= LW'(LOCK_STABLE_CYCLES - 1);
   assign pps_to = pps_cnt_q >= PW'(PPS_TIMEOUT_CYCLES - 1);
   assign rdy_to = rdy_cnt_q >= RW'(READY_TIMEOUT_CYCLES - 1);
   assign ovr = state_q >= WAIT_TIME && (!fc_gps_locked_p || fc_resync_req_p);

   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      missing_d = pps_missing_p;
      lock_cnt_d = '0;
      pps_cnt_d = '0;
      rdy_cnt_d = '0;
      case (state_q)
         IDLE: state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            lock_cnt_d = fc_gps_locked_p ? lock_inc : '0;
            if (lock_done) state_d = WAIT_TIME;
         end
         WAIT_TIME: if (fc_start_time_valid_p) begin
            hold_d = fc_start_time_p;
            state_d = ARM;
         end
         ARM: begin
            missing_d = 1'b0;
            state_d = WAIT_PPS;
         end
         WAIT_PPS: begin
            pps_cnt_d = pps_edge ? '0 : pps_inc;
            if (fc_start_time_valid_p && !pps_edge) hold_d = fc_start_time_p;
            if (pps_edge) state_d = WAIT_READY;
            else if (pps_to) begin
               missing_d = 1'b1;
               state_d = FAULT;
            end
         end
         WAIT_READY: begin
            pps_cnt_d = pps_edge ? '0 : pps_inc;
            rdy_cnt_d = rdy_inc;
            if (timekeeper_ready_p) state_d = SYNCED;
            else if (rdy_to) state_d = FAULT;
         end
         SYNCED: begin
            pps_cnt_d = pps_edge ? '0 : pps_inc;
            if (pps_to && !pps_edge) begin
               missing_d = 1'b1;
               state_d = FAULT;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      // lock loss and FC resync pre-empt every normal transition and its side effects
      if (ovr) begin
         state_d = WAIT_LOCK;
         hold_d = hold_q;
         missing_d = pps_missing_p;
      end
      sync_reg_d = '0;
      sync_reg_d[LOCK_READY_BIT] = state_q inside {ARM, WAIT_PPS, WAIT_READY, SYNCED};
      sync_reg_d[PPS_LOOK_BIT] = state_q inside {ARM, WAIT_PPS};
      sync_reg_d[START_TIME_READY_BIT] = state_q inside {WAIT_READY, SYNCED};
   end

   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         state_q <= IDLE;
         lock_cnt_q <= '0;
         pps_cnt_q <= '0;
         rdy_cnt_q <= '0;
         hold_q <= '0;
         pps_missing_p <= 1'b0;
         FPGA_FC_sync_reg_p <= '0;
      end else begin
         state_q <= state_d;
         lock_cnt_q <= lock_cnt_d;
         pps_cnt_q <= pps_cnt_d;
         rdy_cnt_q <= rdy_cnt_d;
         hold_q <= hold_d;
         pps_missing_p <= missing_d;
         FPGA_FC_sync_reg_p <= sync_reg_d;
      end
   end

   assign FC_GPS_start_time_p = hold_q;
   assign sync_done_p = state_q == SYNCED;
   assign seq_state_p = state_q;
endmodule

// File: tb/tb_timekeeper_sync_sequencer.sv
// tb_timekeeper_sync_sequencer: directed-vector bench for the GPS/PPS sync sequencer
module tb_timekeeper_sync_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, valid = 1'b0, resync = 1'b0, pps = 1'b0, ready = 1'b0;
   logic [63:0] start_time = '0;
   logic [15:0] sync_reg;
   logic [63:0] st_out;
   logic done, missing;
   logic [2:0] state;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   timekeeper_sync_sequencer #(
      .LOCK_STABLE_CYCLES(8),
      .PPS_TIMEOUT_CYCLES(100),
      .READY_TIMEOUT_CYCLES(20),
      .PPS_SYNC_STAGES(2)
   ) dut (
      .clk210_p(clk),
      .reset_p(rst_n),
      .fc_gps_locked_p(locked),
      .fc_start_time_p(start_time),
      .fc_start_time_valid_p(valid),
      .fc_resync_req_p(resync),
      .pps_gps_p(pps),
      .timekeeper_ready_p(ready),
      .FPGA_FC_sync_reg_p(sync_reg),
      .FC_GPS_start_time_p(st_out),
      .sync_done_p(done),
      .pps_missing_p(missing),
      .seq_state_p(state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lock_to_time();
      tick(8);
      check("lock_to_time", state, 2);
   endtask

   task automatic arm(input logic [63:0] t);
      valid = 1'b1;
      start_time = t;
      tick(1);
      valid = 1'b0;
      check("arm_state", state, 3);
      check("arm_latch", st_out, t);
      tick(1);
      check("wait_pps_state", state, 4);
      check("wait_pps_reg", sync_reg, 16'h0003);
   endtask

   initial begin
      #2;
      check("rst_reg", sync_reg, 0);
      check("rst_time", st_out, 0);
      check("rst_done", done, 0);
      check("rst_missing", missing, 0);
      check("rst_state", state, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("idle_to_wait_lock", state, 1);
      // broken lock run, early valid ignored
      locked = 1'b1;
      valid = 1'b1;
      start_time = 64'hDEAD;
      tick(1);
      valid = 1'b0;
      tick(6);
      check("lock7_state", state, 1);
      check("early_valid_ignored", st_out, 0);
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(7);
      check("relock7_state", state, 1);
      check("relock7_reg", sync_reg, 0);
      tick(1);
      check("relock8_state", state, 2);
      check("relock8_reg", sync_reg, 0);
      // nominal sequence
      arm(64'h0000_0001_2345_6789);
      pps = 1'b1;
      tick(2);
      check("pps_not_yet", state, 4);
      tick(1);
      check("pps_edge_state", state, 5);
      check("pps_edge_reg_lag", sync_reg, 16'h0003);
      tick(1);
      check("wait_ready_reg", sync_reg, 16'h0005);
      tick(3);
      ready = 1'b1;
      tick(1);
      check("synced_state", state, 6);
      check("synced_done", done, 1);
      check("synced_time", st_out, 64'h0000_0001_2345_6789);
      tick(1);
      check("synced_reg", sync_reg, 16'h0005);
      // lock loss coincident with pps_edge in SYNCED
      pps = 1'b0;
      tick(3);
      pps = 1'b1;
      tick(2);
      locked = 1'b0;
      ready = 1'b0;
      tick(1);
      check("lockloss_state", state, 1);
      check("lockloss_done", done, 0);
      check("lockloss_reg_lag", sync_reg, 16'h0005);
      tick(1);
      check("lockloss_reg", sync_reg, 0);
      // PPS timeout
      pps = 1'b0;
      locked = 1'b1;
      lock_to_time();
      arm(64'h1111);
      tick(99);
      check("pps_to_pre_state", state, 4);
      check("pps_to_pre_missing", missing, 0);
      tick(1);
      check("pps_to_state", state, 7);
      check("pps_to_missing", missing, 1);
      tick(1);
      check("fault_to_wait_lock", state, 1);
      check("fault_reg", sync_reg, 0);
      check("missing_sticky", missing, 1);
      // latest valid wins; valid coincident with pps_edge discarded
      lock_to_time();
      arm(64'h2222);
      check("missing_cleared", missing, 0);
      valid = 1'b1;
      start_time = 64'hAAAA;
      tick(1);
      valid = 1'b0;
      check("overwrite_state", state, 4);
      check("overwrite_time", st_out, 64'hAAAA);
      pps = 1'b1;
      tick(2);
      valid = 1'b1;
      start_time = 64'hBBBB;
      tick(1);
      valid = 1'b0;
      check("coincident_state", state, 5);
      check("coincident_time", st_out, 64'hAAAA);
      // ready timeout
      pps = 1'b0;
      tick(19);
      check("rdy_to_pre", state, 5);
      tick(1);
      check("rdy_to_fault", state, 7);
      tick(1);
      check("rdy_to_wait_lock", state, 1);
      // async reset mid-WAIT_READY
      lock_to_time();
      arm(64'h3333);
      pps = 1'b1;
      tick(3);
      check("pre_reset_state", state, 5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_reg", sync_reg, 0);
      check("async_rst_time", st_out, 0);
      check("async_rst_done", done, 0);
      check("async_rst_missing", missing, 0);
      check("async_rst_state", state, 0);
      #2 rst_n = 1'b1;
      pps = 1'b0;
      tick(1);
      check("post_rst_wait_lock", state, 1);
      // FC resync request in WAIT_TIME
      lock_to_time();
      resync = 1'b1;
      tick(1);
      resync = 1'b0;
      check("resync_state", state, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
